// File: rtl/histogram_controller.sv
// Sequencer that feeds samples to an external histogram block, waits for its search
// result and hands the captured result to a ready/valid consumer, with drop and watchdog status.
//   state       | meaning
//   IDLE        | waiting for start
//   CLEAR       | one-cycle histogram clear pulse
//   ACQUIRE     | forwarding samples until the histogram reports max count
//   WAIT_RESULT | waiting for the histogram search, guarded by the watchdog
//   PRESENT     | holding the captured result until the consumer accepts it
module histogram_controller #(
    parameter int DATA_WIDTH                           = 4,
    parameter int LOG2_OF_NUMBER_OF_SAMPLES_TO_ACQUIRE = 4,
    parameter int TIMEOUT_CYCLES                       = 255
) (
    input  logic                                             clock,
    input  logic                                             reset_n,
    input  logic                                             start,
    input  logic                                             continuous,
    input  logic                                             abort,
    input  logic                                             data_valid,
    input  logic [DATA_WIDTH-1:0]                            data_in,
    output logic                                             hist_sample,
    output logic [DATA_WIDTH-1:0]                            hist_data,
    output logic                                             hist_clear,
    input  logic                                             hist_max_count_reached,
    input  logic                                             hist_result_valid,
    input  logic [4*DATA_WIDTH-1:0]                          hist_results,
    input  logic [4*LOG2_OF_NUMBER_OF_SAMPLES_TO_ACQUIRE-1:0] hist_counts,
    output logic                                             out_valid,
    input  logic                                             out_ready,
    output logic [4*DATA_WIDTH-1:0]                          out_results,
    output logic [4*LOG2_OF_NUMBER_OF_SAMPLES_TO_ACQUIRE-1:0] out_counts,
    output logic [7:0]                                       out_run_number,
    output logic                                             busy,
    output logic                                             timeout_error,
    output logic [7:0]                                       samples_dropped
);

    typedef enum logic [2:0] {IDLE, CLEAR, ACQUIRE, WAIT_RESULT, PRESENT} state_t;

    localparam logic [15:0] TIMEOUT_TC = 16'(TIMEOUT_CYCLES);

    state_t      state;
    logic [15:0] watchdog;
    logic        forward;
    logic        drop;

    // abort wins over forwarding, so a sample presented alongside abort counts as dropped
    assign forward = (state == ACQUIRE) && !hist_max_count_reached && !abort;
    assign drop    = data_valid && !forward;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            watchdog        <= '0;
            hist_sample     <= 1'b0;
            hist_data       <= '0;
            hist_clear      <= 1'b0;
            out_valid       <= 1'b0;
            out_results     <= '0;
            out_counts      <= '0;
            out_run_number  <= '0;
            busy            <= 1'b0;
            timeout_error   <= 1'b0;
            samples_dropped <= '0;
        end else begin
            hist_clear  <= 1'b0;
            hist_sample <= 1'b0;
            if (drop && samples_dropped != 8'hFF)
                samples_dropped <= samples_dropped + 8'd1;
            if (forward) begin
                hist_sample <= data_valid;
                hist_data   <= data_in;
            end

            if (abort && state != IDLE) begin
                state      <= IDLE;
                busy       <= 1'b0;
                out_valid  <= 1'b0;
                hist_clear <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            state           <= CLEAR;
                            busy            <= 1'b1;
                            hist_clear      <= 1'b1;
                            timeout_error   <= 1'b0;
                            samples_dropped <= '0;
                        end
                    end
                    CLEAR: state <= ACQUIRE;
                    ACQUIRE: begin
                        if (hist_max_count_reached) begin
                            state    <= WAIT_RESULT;
                            watchdog <= '0;
                        end
                    end
                    WAIT_RESULT: begin
                        // a result arriving on the expiry cycle is still taken
                        if (hist_result_valid) begin
                            out_results <= hist_results;
                            out_counts  <= hist_counts;
                            out_valid   <= 1'b1;
                            state       <= PRESENT;
                        end else if (watchdog == TIMEOUT_TC) begin
                            timeout_error <= 1'b1;
                            busy          <= 1'b0;
                            state         <= IDLE;
                        end else begin
                            watchdog <= watchdog + 16'd1;
                        end
                    end
                    PRESENT: begin
                        if (out_ready) begin
                            out_valid      <= 1'b0;
                            out_run_number <= out_run_number + 8'd1;
                            if (continuous) begin
                                state      <= CLEAR;
                                hist_clear <= 1'b1;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
